// File: rtl/param_stack_pkg.sv
// Shared definitions for the parameterised stack: op encodings and default sizes.
package param_stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_WRITE = 3'd3,
        OP_DUP   = 3'd4,
        OP_SWAP  = 3'd5,
        OP_CLEAR = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 64;

endpackage

// File: rtl/param_stack_regfile.sv
// Stack storage: DEPTH x WIDTH registers, two combinational read ports and
// two write ports. Port 1 exists only so SWAP can exchange two entries in one
// cycle. Contents are never reset; validity is tracked by the parent's count.
module stack_regfile #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  logic [WIDTH-1:0] wdata1
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

    // Per-entry write; the two ports never target the same entry in practice.
    always_ff @(posedge clock) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (we0 && waddr0 == AW'(e))
                mem[e] <= wdata0;
            else if (we1 && waddr1 == AW'(e))
                mem[e] <= wdata1;
        end
    end

endmodule

// File: rtl/param_stack.sv
// LIFO stack with PUSH/POP/WRITE/DUP/SWAP/CLEAR, one op per cycle, and
// sticky overflow/underflow flags. Storage lives in stack_regfile; count,
// flags and op decode live here.
module param_stack
    import param_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [2:0]               op,
    input  logic                     op_valid,
    input  logic [WIDTH-1:0]         value,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         top,
    output logic [WIDTH-1:0]         next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]    cnt, cnt_nxt;
    logic             ovf_q, unf_q;
    logic             ovf_evt, unf_evt, do_clear;
    logic             is_empty, is_full, has2, exec;
    logic [AW-1:0]    top_idx, next_idx;
    logic [WIDTH-1:0] rdata0, rdata1;
    logic             we0, we1;
    logic [AW-1:0]    waddr0, waddr1;
    logic [WIDTH-1:0] wdata0, wdata1;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CW'(DEPTH));
    assign has2     = (cnt >= CW'(2));
    // When count==DEPTH the low bits are 0, so minus one still lands on DEPTH-1.
    assign top_idx  = cnt[AW-1:0] - AW'(1);
    assign next_idx = cnt[AW-1:0] - AW'(2);
    // Ops are only sampled while out of reset so storage stays untouched too.
    assign exec     = op_valid & reset_n;

    stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rf (
        .clock  (clock),
        .raddr0 (top_idx),
        .raddr1 (next_idx),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .we0    (we0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (wdata1)
    );

    // Decode the op into write-port controls, next count and error events.
    // Failing ops leave every write enable low and the count unchanged.
    always_comb begin
        cnt_nxt  = cnt;
        we0      = 1'b0;
        we1      = 1'b0;
        waddr0   = cnt[AW-1:0];
        wdata0   = value;
        waddr1   = next_idx;
        wdata1   = rdata0;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        do_clear = 1'b0;
        if (exec) begin
            case (op_e'(op))
                OP_PUSH: begin
                    if (is_full) ovf_evt = 1'b1;
                    else begin
                        we0     = 1'b1;
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                OP_POP: begin
                    if (is_empty) unf_evt = 1'b1;
                    else cnt_nxt = cnt - CW'(1);
                end
                OP_WRITE: begin
                    if (is_empty) unf_evt = 1'b1;
                    else begin
                        we0    = 1'b1;
                        waddr0 = top_idx;
                    end
                end
                OP_DUP: begin
                    if (is_empty) unf_evt = 1'b1;
                    else if (is_full) ovf_evt = 1'b1;
                    else begin
                        we0     = 1'b1;
                        wdata0  = rdata0;
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                OP_SWAP: begin
                    if (!has2) unf_evt = 1'b1;
                    else begin
                        we0    = 1'b1;
                        waddr0 = top_idx;
                        wdata0 = rdata1;
                        we1    = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    cnt_nxt  = '0;
                    do_clear = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else          cnt <= cnt_nxt;
    end

    // Sticky flags: CLEAR wipes them; otherwise a new event beats err_clr.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (do_clear) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~err_clr) | ovf_evt;
            unf_q <= (unf_q & ~err_clr) | unf_evt;
        end
    end

    assign top       = is_empty ? '0 : rdata0;
    assign next      = has2 ? rdata1 : '0;
    assign count     = cnt;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack: a queue-based reference stack predicts the
// full output state for every step; predictions go through a scoreboard
// queue and are checked after the clock edge, alongside fixed spot values.
module tb_param_stack;
    import param_stack_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  op;
    logic        op_valid;
    logic [31:0] value;
    logic        err_clr;

    logic [31:0] a_top, a_next;
    logic [6:0]  a_count;
    logic        a_empty, a_full, a_ovf, a_unf;
    logic [7:0]  b_top, b_next;
    logic [2:0]  b_count;
    logic        b_empty, b_full, b_ovf, b_unf;

    param_stack dut_a (
        .clock(clock), .reset_n(reset_n), .op(op), .op_valid(op_valid),
        .value(value), .err_clr(err_clr), .top(a_top), .next(a_next),
        .count(a_count), .empty(a_empty), .full(a_full),
        .overflow(a_ovf), .underflow(a_unf)
    );

    param_stack #(.WIDTH(8), .DEPTH(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .op(op), .op_valid(op_valid),
        .value(value[7:0]), .err_clr(err_clr), .top(b_top), .next(b_next),
        .count(b_count), .empty(b_empty), .full(b_full),
        .overflow(b_ovf), .underflow(b_unf)
    );

    always #5 clock = ~clock;

    // Observed outputs of whichever instance is under test.
    logic        sel = 1'b0;
    logic [31:0] o_top, o_next, o_count;
    logic        o_empty, o_full, o_ovf, o_unf;
    always_comb begin
        o_top   = sel ? {24'd0, b_top}   : a_top;
        o_next  = sel ? {24'd0, b_next}  : a_next;
        o_count = sel ? {29'd0, b_count} : {25'd0, a_count};
        o_empty = sel ? b_empty : a_empty;
        o_full  = sel ? b_full  : a_full;
        o_ovf   = sel ? b_ovf   : a_ovf;
        o_unf   = sel ? b_unf   : a_unf;
    end

    typedef struct {
        string       tag;
        logic [31:0] top, next, count;
        logic        empty, full, ovf, unf;
    } exp_t;

    exp_t          sb[$];
    logic [31:0]   mdl[$];
    logic          m_ovf, m_unf;
    int            cur_depth = 64;
    logic [31:0]   cur_mask  = 32'hFFFF_FFFF;
    int            n_asrt = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        mdl.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Reference behaviour written from the op definitions.
    task automatic mdl_apply(input logic [2:0] o, input logic v, input logic [31:0] val,
                             input logic ec);
        logic eo, eu;
        logic [31:0] t;
        int n;
        eo = 1'b0;
        eu = 1'b0;
        n  = mdl.size();
        if (v && o == OP_CLEAR) begin
            mdl.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        if (v) begin
            case (o)
                OP_PUSH:  if (n == cur_depth) eo = 1'b1; else mdl.push_back(val & cur_mask);
                OP_POP:   if (n == 0) eu = 1'b1; else void'(mdl.pop_back());
                OP_WRITE: if (n == 0) eu = 1'b1; else mdl[n-1] = val & cur_mask;
                OP_DUP: begin
                    if (n == 0) eu = 1'b1;
                    else if (n == cur_depth) eo = 1'b1;
                    else mdl.push_back(mdl[n-1]);
                end
                OP_SWAP: begin
                    if (n < 2) eu = 1'b1;
                    else begin
                        t        = mdl[n-1];
                        mdl[n-1] = mdl[n-2];
                        mdl[n-2] = t;
                    end
                end
                default: ;
            endcase
        end
        if (ec) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        m_ovf = m_ovf | eo;
        m_unf = m_unf | eu;
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        int n;
        n       = mdl.size();
        e.tag   = tag;
        e.top   = (n > 0) ? mdl[n-1] : 32'd0;
        e.next  = (n > 1) ? mdl[n-2] : 32'd0;
        e.count = 32'(n);
        e.empty = (n == 0);
        e.full  = (n == cur_depth);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".top"},   o_top,   e.top);
        chk({e.tag, ".next"},  o_next,  e.next);
        chk({e.tag, ".count"}, o_count, e.count);
        chk({e.tag, ".empty"}, 32'(o_empty), 32'(e.empty));
        chk({e.tag, ".full"},  32'(o_full),  32'(e.full));
        chk({e.tag, ".ovf"},   32'(o_ovf),   32'(e.ovf));
        chk({e.tag, ".unf"},   32'(o_unf),   32'(e.unf));
    endtask

    task automatic check_now(input string tag);
        push_exp(tag);
        check_pop();
    endtask

    // Drive one op, predict its result, then compare one step after the edge.
    task automatic step(input string tag, input logic [2:0] o, input logic v,
                        input logic [31:0] val, input logic ec);
        op       = o;
        op_valid = v;
        value    = val;
        err_clr  = ec;
        mdl_apply(o, v, val, ec);
        push_exp(tag);
        @(posedge clock);
        #1;
        check_pop();
        op_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b1;
        op       = 3'd0;
        op_valid = 1'b0;
        value    = '0;
        err_clr  = 1'b0;
        mdl_reset();
        #2 reset_n = 1'b0;
        #10;
        check_now("reset");
        #1 reset_n = 1'b1;

        // Basic push / swap / dup
        step("push5", OP_PUSH, 1'b1, 32'd5, 1'b0);
        step("push7", OP_PUSH, 1'b1, 32'd7, 1'b0);
        chk("r033_top7", o_top, 32'd7);
        chk("r033_next5", o_next, 32'd5);
        chk("r033_cnt2", o_count, 32'd2);
        step("swap", OP_SWAP, 1'b1, 32'd0, 1'b0);
        chk("r033_swap_top", o_top, 32'd5);
        chk("r033_swap_next", o_next, 32'd7);
        step("dup", OP_DUP, 1'b1, 32'd0, 1'b0);
        chk("r033_dup_top", o_top, 32'd5);
        chk("r033_dup_cnt", o_count, 32'd3);
        step("write", OP_WRITE, 1'b1, 32'hABCD_1234, 1'b0);
        step("nop7", 3'd7, 1'b1, 32'h55, 1'b0);
        step("novalid", OP_PUSH, 1'b0, 32'h66, 1'b0);

        // Fill to capacity and overflow
        step("clear0", OP_CLEAR, 1'b1, 32'd0, 1'b0);
        for (int i = 0; i < 64; i++)
            step($sformatf("fill%0d", i), OP_PUSH, 1'b1, 32'(i), 1'b0);
        chk("r034_full", 32'(o_full), 32'd1);
        chk("r034_cnt64", o_count, 32'd64);
        step("push_ovf", OP_PUSH, 1'b1, 32'hFFFF, 1'b0);
        chk("r034_ovf_top", o_top, 32'd63);
        chk("r034_ovf_cnt", o_count, 32'd64);
        chk("r034_ovf", 32'(o_ovf), 32'd1);
        step("dup_full", OP_DUP, 1'b1, 32'd0, 1'b0);
        step("pop_full", OP_POP, 1'b1, 32'd0, 1'b0);
        chk("r034_pop_top", o_top, 32'd62);
        chk("r034_pop_cnt", o_count, 32'd63);
        chk("r034_ovf_sticky", 32'(o_ovf), 32'd1);
        step("swap_deep", OP_SWAP, 1'b1, 32'd0, 1'b0);

        // Underflow on an empty stack
        step("clear1", OP_CLEAR, 1'b1, 32'd0, 1'b0);
        chk("r022_clr_ovf", 32'(o_ovf), 32'd0);
        step("pop_e", OP_POP, 1'b1, 32'd0, 1'b0);
        step("write_e", OP_WRITE, 1'b1, 32'd9, 1'b0);
        step("swap_e", OP_SWAP, 1'b1, 32'd0, 1'b0);
        chk("r035_cnt", o_count, 32'd0);
        chk("r035_top", o_top, 32'd0);
        chk("r035_unf", 32'(o_unf), 32'd1);
        step("errclr", OP_NOP, 1'b0, 32'd0, 1'b1);
        chk("r035_unf_clr", 32'(o_unf), 32'd0);

        // err_clr racing an op that does or does not fail
        step("push_one", OP_PUSH, 1'b1, 32'd11, 1'b0);
        step("swap_one", OP_SWAP, 1'b1, 32'd0, 1'b0);
        step("pop_ec", OP_POP, 1'b1, 32'd0, 1'b1);
        chk("r036_cnt0", o_count, 32'd0);
        chk("r036_unf0", 32'(o_unf), 32'd0);
        step("pop_ec2", OP_POP, 1'b1, 32'd0, 1'b1);
        chk("r036_unf1", 32'(o_unf), 32'd1);

        // Mixed ops against the reference
        for (int i = 0; i < 80; i++) begin
            logic [2:0] ro;
            ro = 3'($urandom_range(0, 7));
            if (ro == OP_CLEAR && $urandom_range(0, 3) != 0) ro = OP_PUSH;
            step($sformatf("rnd%0d", i), ro, ($urandom_range(0, 9) != 0),
                 $urandom, ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset in the middle of an op
        step("clear2", OP_CLEAR, 1'b1, 32'd0, 1'b0);
        step("p1", OP_PUSH, 1'b1, 32'd1, 1'b0);
        step("p2", OP_PUSH, 1'b1, 32'd2, 1'b0);
        step("p3", OP_PUSH, 1'b1, 32'd3, 1'b0);
        op       = OP_PUSH;
        op_valid = 1'b1;
        value    = 32'd99;
        #2 reset_n = 1'b0;
        #1;
        mdl_reset();
        check_now("rst_async");
        chk("r037_cnt0", o_count, 32'd0);
        chk("r037_empty", 32'(o_empty), 32'd1);
        @(posedge clock);
        #1;
        check_now("rst_hold");
        reset_n = 1'b1;
        step("push4", OP_PUSH, 1'b1, 32'd4, 1'b0);
        chk("r037_top4", o_top, 32'd4);
        chk("r037_cnt1", o_count, 32'd1);

        // Small instance: WIDTH=8, DEPTH=4
        op_valid  = 1'b0;
        reset_n   = 1'b0;
        sel       = 1'b1;
        cur_depth = 4;
        cur_mask  = 32'hFF;
        mdl_reset();
        #3;
        check_now("b_reset");
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++)
            step($sformatf("b_push%0d", i), OP_PUSH, 1'b1, 32'h1A0 + 32'(i), 1'b0);
        chk("r038_full", 32'(o_full), 32'd1);
        chk("r038_cnt4", o_count, 32'd4);
        step("b_ovf", OP_PUSH, 1'b1, 32'h77, 1'b0);
        step("b_dup_full", OP_DUP, 1'b1, 32'd0, 1'b0);
        step("b_swap", OP_SWAP, 1'b1, 32'd0, 1'b0);
        step("b_clear", OP_CLEAR, 1'b1, 32'd0, 1'b0);
        chk("r038_cnt0", o_count, 32'd0);
        chk("r038_ovf0", 32'(o_ovf), 32'd0);
        step("b_push_after", OP_PUSH, 1'b1, 32'h3C5, 1'b0);

        op_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
